// File: rtl/regfile.sv
// CPU register file: eight GPRs plus SP/IH/RA and the T flag, with two combinational
// GPR read ports and same-cycle write-to-read bypass on every output.
module regfile #(
  parameter logic [15:0] SP_INIT = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  rx_addr,
  input  logic [2:0]  ry_addr,
  output logic [15:0] rx_data,
  output logic [15:0] ry_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        t_written,
  input  logic        t_in,
  output logic [15:0] sp_out,
  output logic [15:0] ih_out,
  output logic [15:0] ra_out,
  output logic        t_out
);

  localparam logic [3:0] ADDR_SP = 4'd8;
  localparam logic [3:0] ADDR_IH = 4'd9;
  localparam logic [3:0] ADDR_RA = 4'd10;

  logic [15:0] gpr_q [8];
  logic [15:0] gpr_d [8];
  logic [15:0] sp_q, sp_d;
  logic [15:0] ih_q, ih_d;
  logic [15:0] ra_q, ra_d;
  logic        t_q, t_d;

  logic wr_fire;
  logic t_fire;

  // Reset takes priority over everything, so it also switches the bypass off.
  assign wr_fire = wr_en && !stall && !rst;
  assign t_fire  = t_written && !stall && !rst;

  always_comb begin
    gpr_d = gpr_q;
    sp_d  = sp_q;
    ih_d  = ih_q;
    ra_d  = ra_q;
    t_d   = t_q;
    if (wr_fire) begin
      if (!wr_addr[3]) begin
        gpr_d[wr_addr[2:0]] = wr_data;
      end else begin
        case (wr_addr)
          ADDR_SP: sp_d = wr_data;
          ADDR_IH: ih_d = wr_data;
          ADDR_RA: ra_d = wr_data;
          default: ;
        endcase
      end
    end
    if (t_fire) begin
      t_d = t_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        gpr_q[i] <= '0;
      end
      sp_q <= SP_INIT;
      ih_q <= '0;
      ra_q <= '0;
      t_q  <= 1'b0;
    end else begin
      gpr_q <= gpr_d;
      sp_q  <= sp_d;
      ih_q  <= ih_d;
      ra_q  <= ra_d;
      t_q   <= t_d;
    end
  end

  always_comb begin
    rx_data = gpr_q[rx_addr];
    ry_data = gpr_q[ry_addr];
    sp_out  = sp_q;
    ih_out  = ih_q;
    ra_out  = ra_q;
    t_out   = t_q;
    if (wr_fire && (wr_addr == {1'b0, rx_addr})) rx_data = wr_data;
    if (wr_fire && (wr_addr == {1'b0, ry_addr})) ry_data = wr_data;
    if (wr_fire && (wr_addr == ADDR_SP))         sp_out  = wr_data;
    if (wr_fire && (wr_addr == ADDR_IH))         ih_out  = wr_data;
    if (wr_fire && (wr_addr == ADDR_RA))         ra_out  = wr_data;
    if (t_fire)                                  t_out   = t_in;
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the stimulus side predicts outputs from an array model
// and queues them; a negedge monitor pops and compares against the live outputs.
module tb_regfile;

  localparam logic [15:0] SP_INIT = 16'hBF00;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [2:0]  rx_addr, ry_addr;
  logic [15:0] rx_data, ry_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        t_written, t_in;
  logic [15:0] sp_out, ih_out, ra_out;
  logic        t_out;

  regfile #(.SP_INIT(SP_INIT)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rx_addr(rx_addr), .ry_addr(ry_addr),
    .rx_data(rx_data), .ry_data(ry_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .t_written(t_written), .t_in(t_in),
    .sp_out(sp_out), .ih_out(ih_out), .ra_out(ra_out), .t_out(t_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [15:0] rx, ry, sp, ih, ra;
    logic        t;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: index 0-7 = R0-R7, 8 = SP, 9 = IH, 10 = RA.
  logic [15:0] m_reg [11];
  logic        m_t;
  bit          m_known = 0;
  int          step_no = 0;

  function automatic logic [15:0] predict(input int target);
    if (!rst && !stall && wr_en && int'(wr_addr) == target) return wr_data;
    return m_reg[target];
  endfunction

  task automatic step(input logic r, input logic s, input logic [2:0] xa, input logic [2:0] ya,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic tw, input logic ti);
    exp_t e;
    rst = r; stall = s; rx_addr = xa; ry_addr = ya;
    wr_en = we; wr_addr = wa; wr_data = wd; t_written = tw; t_in = ti;
    if (m_known) begin
      e.step = step_no;
      e.rx = predict(int'(xa));
      e.ry = predict(int'(ya));
      e.sp = predict(8);
      e.ih = predict(9);
      e.ra = predict(10);
      e.t  = (!r && !s && tw) ? ti : m_t;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = 16'h0000;
      m_reg[8] = SP_INIT;
      m_t = 1'b0;
      m_known = 1;
    end else if (!s) begin
      if (we && wa <= 4'd10) m_reg[wa] = wd;
      if (tw) m_t = ti;
    end
    step_no++;
    #1;
  endtask

  task automatic chk(input string name, input int stp, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, stp, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rx_data", e.step, rx_data, e.rx);
      chk("ry_data", e.step, ry_data, e.ry);
      chk("sp_out",  e.step, sp_out,  e.sp);
      chk("ih_out",  e.step, ih_out,  e.ih);
      chk("ra_out",  e.step, ra_out,  e.ra);
      chk("t_out",   e.step, {15'd0, t_out}, {15'd0, e.t});
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // Reset, then read R3/R7 and the specials.
    step(1, 0, 3, 7, 0, 0, 16'h0000, 0, 0);
    step(0, 0, 3, 7, 0, 0, 16'h0000, 0, 0);
    // R5 write with same-cycle bypass, then held value.
    step(0, 0, 5, 0, 1, 5, 16'h1234, 0, 0);
    step(0, 0, 5, 0, 0, 5, 16'h0000, 0, 0);
    // Stalled write to R2 is dropped and not bypassed.
    step(0, 1, 0, 2, 1, 2, 16'hAAAA, 1, 1);
    step(0, 0, 0, 2, 0, 0, 16'h0000, 0, 0);
    // SP and T written on the same edge.
    step(0, 0, 0, 0, 1, 8, 16'h00FF, 1, 1);
    step(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    // IH and RA writes.
    step(0, 0, 0, 0, 1, 9, 16'hC0DE, 0, 0);
    step(0, 0, 0, 0, 1, 10, 16'h8001, 1, 0);
    // Write coincident with reset is discarded; bypass off during reset.
    step(0, 0, 1, 1, 1, 1, 16'h7777, 0, 0);
    step(1, 1, 1, 5, 1, 1, 16'h5555, 1, 1);
    step(0, 0, 1, 5, 0, 0, 16'h0000, 0, 0);
    // Writes to 11-15 touch nothing.
    step(0, 0, 0, 0, 1, 4, 16'h0042, 0, 0);
    for (int a = 11; a < 16; a++) step(0, 0, 4, 4, 1, 4'(a), 16'hFFFF, 0, 0);
    step(0, 0, 4, 4, 0, 0, 16'h0000, 0, 0);
    step(0, 0, 6, 6, 1, 6, 16'h9A9A, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
